// File: rtl/rf_sb.sv
// Register file: NUM_RD combinational read ports, two byte-enabled write ports, and a busy scoreboard.
// Optional macro RF_WR_BYPASS_EN forwards same-cycle write data and busy clears to the read ports.
module rf_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
) (
    input  logic                     rf_clk,
    input  logic                     rf_rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W/8-1:0]      wa_be,
    input  logic [DATA_W/8-1:0]      wb_be,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wa_clr,
    input  logic                     wb_clr,
    input  logic                     iss_vld,
    input  logic [ADDR_W-1:0]        iss_reg,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_clr_s;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    function automatic logic [ADDR_W:0] popcnt(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Merged next register contents: port A first, then port B so B wins on overlapping bytes.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NB; k++) begin
            mem_d[wa_addr][k*8 +: 8] = (wa_en && wa_be[k]) ? wa_data[k*8 +: 8]
                                                            : mem_d[wa_addr][k*8 +: 8];
            mem_d[wb_addr][k*8 +: 8] = (wb_en && wb_be[k]) ? wb_data[k*8 +: 8]
                                                            : mem_d[wb_addr][k*8 +: 8];
        end
        mem_d[0] = {DATA_W{1'b0}};
    end

    // Scoreboard next state: clears applied before the issue set so a new producer wins.
    always_comb begin
        busy_clr_s          = busy_q;
        busy_clr_s[wa_addr] = busy_clr_s[wa_addr] & ~(wa_en & wa_clr);
        busy_clr_s[wb_addr] = busy_clr_s[wb_addr] & ~(wb_en & wb_clr);
        busy_d              = busy_clr_s;
        busy_d[iss_reg]     = busy_d[iss_reg] | iss_vld;
        busy_d[0]           = 1'b0;
        busy_cnt_d          = popcnt(busy_d);
    end

    // State registers with synchronous reset taking priority over all updates.
    always_ff @(posedge rf_clk) begin
        if (rf_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            busy_q     <= {DEPTH{1'b0}};
            busy_cnt_q <= {(ADDR_W+1){1'b0}};
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd_data = {(NUM_RD*DATA_W){1'b0}};
        rd_busy = {NUM_RD{1'b0}};
        for (int i = 0; i < NUM_RD; i++) begin
`ifdef RF_WR_BYPASS_EN
            rd_data[i*DATA_W +: DATA_W] = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy[i]                  = busy_clr_s[rd_addr[i*ADDR_W +: ADDR_W]];
`else
            rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            rd_busy[i]                  = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
